// File: rtl/fifo_pkg.sv
// fifo_pkg: shared state encoding and pointer helpers
// for the parametrised show-ahead FIFO.
package fifo_pkg;

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_FULL   = 2'd2;

  // Advance a pointer, wrapping at depth-1 (any depth).
  function automatic int unsigned ptr_inc(
    input int unsigned p,
    input int unsigned depth
  );
    return (p == depth - 32'd1) ? 32'd0 : p + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: WIDTH x DEPTH register array,
// synchronous write, asynchronous read.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [PW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_ctrl_param.sv
// fifo_ctrl_param: synchronous FIFO with valid/ready,
// occupancy, watermarks and EMPTY/ACTIVE/FULL status.
module fifo_ctrl_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int PW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [1:0]       state,
  output logic             ovf_err,
  output logic             udf_err
);

  import fifo_pkg::*;

  if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_lvl
    $error("fifo_ctrl_param: need AE_LEVEL < AF_LEVEL <= DEPTH");
  end
  if (DEPTH < 2 || WIDTH < 1) begin : g_bad_size
    $error("fifo_ctrl_param: need DEPTH >= 2 and WIDTH >= 1");
  end

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [1:0]    r_state;
  logic          r_af;
  logic          r_ae;
  logic          r_ovf;
  logic          r_udf;

  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_state_nxt;
  logic [PW-1:0] w_wr_inc;
  logic [PW-1:0] w_rd_inc;
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_wr;
  logic          w_rd;
  logic          w_we;

  assign w_wr_inc = PW'(ptr_inc(32'(r_wr_ptr), DEPTH));
  assign w_rd_inc = PW'(ptr_inc(32'(r_rd_ptr), DEPTH));

  assign w_wr = in_valid & w_in_ready;
  assign w_rd = w_out_valid & out_ready;
  // A write that coincides with flush is dropped.
  assign w_we = w_wr & ~flush;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (out_data)
  );

  // Next occupancy; flush wins over any transfer.
  always_comb begin
    w_cnt_nxt = r_count;
    if (flush) begin
      w_cnt_nxt = '0;
    end else if (w_wr && !w_rd) begin
      w_cnt_nxt = r_count + CW'(1);
    end else if (w_rd && !w_wr) begin
      w_cnt_nxt = r_count - CW'(1);
    end
  end

  // Status FSM: state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Status FSM: next state from the next occupancy.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_wr) w_state_nxt = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (w_cnt_nxt == CW'(DEPTH))
            w_state_nxt = ST_FULL;
          else if (w_cnt_nxt == '0)
            w_state_nxt = ST_EMPTY;
        end
        ST_FULL: begin
          if (w_rd) w_state_nxt = ST_ACTIVE;
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Status FSM: handshake outputs decoded from state.
  always_comb begin
    w_in_ready  = (r_state != ST_FULL);
    w_out_valid = (r_state != ST_EMPTY);
  end

  // Pointer advance with wrap; flush rewinds both.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= w_wr_inc;
      if (w_rd) r_rd_ptr <= w_rd_inc;
    end
  end

  // Count and watermarks track the same next value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
      r_af    <= 1'b0;
      r_ae    <= 1'b1;
    end else begin
      r_count <= w_cnt_nxt;
      r_af    <= (w_cnt_nxt >= CW'(AF_LEVEL));
      r_ae    <= (w_cnt_nxt <= CW'(AE_LEVEL));
    end
  end

  // Sticky misuse flags; only reset clears them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (in_valid && r_state == ST_FULL)   r_ovf <= 1'b1;
      if (out_ready && r_state == ST_EMPTY) r_udf <= 1'b1;
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = w_out_valid;
  assign count        = r_count;
  assign state        = r_state;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign ovf_err      = r_ovf;
  assign udf_err      = r_udf;

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// tb_fifo_ctrl_param: directed checks of the FIFO
// at DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
module tb_fifo_ctrl_param;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          almost_empty;
  logic [1:0]    state;
  logic          ovf_err;
  logic          udf_err;

  int vec = 0;
  int err = 0;

  fifo_ctrl_param #(
    .WIDTH(W), .DEPTH(D), .AF_LEVEL(3), .AE_LEVEL(1)
  ) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready),
    .count(count), .almost_full(almost_full),
    .almost_empty(almost_empty), .state(state),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    #2;
    vec++; if (count !== 3'd0) begin err++;
      $display("FAIL rst_count got %0d want 0", count); end
    vec++; if (state !== 2'd0) begin err++;
      $display("FAIL rst_state got %0d want 0", state); end
    vec++; if ({in_ready, out_valid} !== 2'b10) begin err++;
      $display("FAIL rst_hs got %b want 10", {in_ready, out_valid}); end
    vec++; if ({almost_full, almost_empty} !== 2'b01) begin err++;
      $display("FAIL rst_wm got %b want 01", {almost_full, almost_empty}); end
    vec++; if ({ovf_err, udf_err} !== 2'b00) begin err++;
      $display("FAIL rst_err got %b want 00", {ovf_err, udf_err}); end
    step();
    rstn = 1'b1;
    step();
    step();
    vec++; if ({count, state, in_ready, out_valid, almost_empty}
               !== {3'd0, 2'd0, 1'b1, 1'b0, 1'b1}) begin err++;
      $display("FAIL idle got c=%0d s=%0d ir=%b ov=%b ae=%b want 0 0 1 0 1",
               count, state, in_ready, out_valid, almost_empty); end
  endtask

  task automatic test_fill();
    logic [1:0] es;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1;
      in_data  = W'(8'hA0 + k);
      step();
      es = (k == 4) ? 2'd2 : 2'd1;
      vec++; if (count !== CW'(k)) begin err++;
        $display("FAIL fill_count[%0d] got %0d want %0d", k, count, k); end
      vec++; if (state !== es) begin err++;
        $display("FAIL fill_state[%0d] got %0d want %0d", k, state, es); end
      vec++; if (in_ready !== (k != 4)) begin err++;
        $display("FAIL fill_ready[%0d] got %b want %b", k, in_ready, k != 4); end
      vec++; if (almost_full !== (k >= 3)) begin err++;
        $display("FAIL fill_af[%0d] got %b want %b", k, almost_full, k >= 3); end
      vec++; if (almost_empty !== (k <= 1)) begin err++;
        $display("FAIL fill_ae[%0d] got %b want %b", k, almost_empty, k <= 1); end
      vec++; if (out_data !== 8'hA1) begin err++;
        $display("FAIL fill_head[%0d] got %h want a1", k, out_data); end
    end
    vec++; if (ovf_err !== 1'b0) begin err++;
      $display("FAIL fill_ovf got %b want 0", ovf_err); end
  endtask

  task automatic test_overflow_drain();
    logic [W-1:0] ed;
    in_valid = 1'b1;
    in_data  = 8'h55;
    step();
    vec++; if (ovf_err !== 1'b1) begin err++;
      $display("FAIL ovf_set got %b want 1", ovf_err); end
    step();
    in_valid = 1'b0;
    step();
    vec++; if (count !== 3'd4) begin err++;
      $display("FAIL ovf_count got %0d want 4", count); end
    vec++; if (ovf_err !== 1'b1) begin err++;
      $display("FAIL ovf_sticky got %b want 1", ovf_err); end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      ed = W'(8'hA0 + i);
      vec++; if (out_data !== ed) begin err++;
        $display("FAIL drain_data[%0d] got %h want %h", i, out_data, ed); end
      step();
    end
    out_ready = 1'b0;
    vec++; if ({count, state, out_valid} !== {3'd0, 2'd0, 1'b0}) begin err++;
      $display("FAIL drain_end got c=%0d s=%0d ov=%b want 0 0 0",
               count, state, out_valid); end
    vec++; if (udf_err !== 1'b0) begin err++;
      $display("FAIL drain_udf got %b want 0", udf_err); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] q[$];
    logic [W-1:0] nv;
    logic [1:0]   es;
    logic         mwr;
    logic         mrd;
    nv = 8'h10;
    for (int it = 0; it < 4; it++) begin
      for (int j = 0; j < 3; j++) begin
        in_valid  = 1'b1;
        in_data   = nv;
        out_ready = (j != 0);
        mwr = (q.size() != D);
        mrd = out_ready && (q.size() != 0);
        if (mrd) begin
          vec++; if (out_data !== q[0]) begin err++;
            $display("FAIL wrap_data[%0d.%0d] got %h want %h",
                     it, j, out_data, q[0]); end
        end
        step();
        if (mrd) void'(q.pop_front());
        if (mwr) begin
          q.push_back(nv);
          nv = nv + 8'd1;
        end
        es = (q.size() == 0) ? 2'd0 : (q.size() == D) ? 2'd2 : 2'd1;
        vec++; if (count !== CW'(q.size())) begin err++;
          $display("FAIL wrap_count[%0d.%0d] got %0d want %0d",
                   it, j, count, q.size()); end
        vec++; if (state !== es) begin err++;
          $display("FAIL wrap_state[%0d.%0d] got %0d want %0d",
                   it, j, state, es); end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    vec++; if ({count, state} !== {3'd0, 2'd0}) begin err++;
      $display("FAIL flush0 got c=%0d s=%0d want 0 0", count, state); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vec++; if ({udf_err, count} !== {1'b1, 3'd0}) begin err++;
      $display("FAIL udf got u=%b c=%0d want 1 0", udf_err, count); end
    in_valid = 1'b1;
    in_data  = 8'hC1;
    step();
    in_data  = 8'hC2;
    step();
    vec++; if (count !== 3'd2) begin err++;
      $display("FAIL pre_flush got %0d want 2", count); end
    in_data = 8'h77;
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    vec++; if ({count, state, out_valid} !== {3'd0, 2'd0, 1'b0}) begin err++;
      $display("FAIL flush_cs got c=%0d s=%0d ov=%b want 0 0 0",
               count, state, out_valid); end
    vec++; if ({almost_full, almost_empty} !== 2'b01) begin err++;
      $display("FAIL flush_wm got %b want 01", {almost_full, almost_empty}); end
    vec++; if ({ovf_err, udf_err} !== 2'b11) begin err++;
      $display("FAIL flush_err got %b want 11", {ovf_err, udf_err}); end
    in_valid = 1'b1;
    in_data  = 8'h88;
    step();
    in_valid = 1'b0;
    vec++; if ({count, out_data} !== {3'd1, 8'h88}) begin err++;
      $display("FAIL post_flush got c=%0d d=%h want 1 88", count, out_data); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    in_data  = 8'hD1;
    step();
    in_data  = 8'hD2;
    step();
    in_data  = 8'hD3;
    vec++; if (count !== 3'd3) begin err++;
      $display("FAIL mid_pre got %0d want 3", count); end
    #2 rstn = 1'b0;
    #1;
    vec++; if ({count, state, in_ready, out_valid} !== {3'd0, 2'd0, 1'b1, 1'b0})
    begin err++;
      $display("FAIL mid_rst got c=%0d s=%0d ir=%b ov=%b want 0 0 1 0",
               count, state, in_ready, out_valid); end
    vec++; if ({almost_full, almost_empty, ovf_err, udf_err} !== 4'b0100)
    begin err++;
      $display("FAIL mid_rst_flags got %b want 0100",
               {almost_full, almost_empty, ovf_err, udf_err}); end
    in_valid = 1'b0;
    #1 rstn = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h99;
    step();
    in_valid = 1'b0;
    vec++; if ({count, state, out_data} !== {3'd1, 2'd1, 8'h99}) begin err++;
      $display("FAIL resume got c=%0d s=%0d d=%h want 1 1 99",
               count, state, out_data); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vec++; if ({count, state} !== {3'd0, 2'd0}) begin err++;
      $display("FAIL resume_rd got c=%0d s=%0d want 0 0", count, state); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_drain();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
